// File: rtl/sw_input_pkg.sv
// Shared register offsets and base address for the switch-input MMIO block.
package sw_input_pkg;

  localparam logic [1:0]  SWIN_DATA  = 2'd0;
  localparam logic [1:0]  SWIN_RISE  = 2'd1;
  localparam logic [1:0]  SWIN_FALL  = 2'd2;
  localparam logic [1:0]  SWIN_IRQEN = 2'd3;

  localparam logic [31:0] SWIN_BASE  = 32'h0000_7F00;

endpackage

// File: rtl/sw_debounce_bit.sv
// One switch input: two-flop synchroniser, stability counter and debounced level.
module sw_debounce_bit #(
  parameter int DB_CYCLES = 1000000
) (
  input  logic clk,
  input  logic rstn,
  input  logic raw,
  output logic q,
  output logic rise,
  output logic fall
);

  localparam int             CW      = $clog2(DB_CYCLES);
  localparam logic [CW-1:0]  CNT_MAX = CW'(DB_CYCLES - 1);

  logic          s1_q, s1_d;
  logic          s2_q, s2_d;
  logic          q_q, q_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // rise/fall are single-cycle pulses on the edge where q takes the new level
  always_comb begin
    s1_d  = raw;
    s2_d  = s1_q;
    q_d   = q_q;
    cnt_d = cnt_q;
    rise  = 1'b0;
    fall  = 1'b0;
    if (s2_q == q_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_MAX) begin
      q_d   = s2_q;
      cnt_d = '0;
      rise  = s2_q;
      fall  = ~s2_q;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      s1_q  <= 1'b0;
      s2_q  <= 1'b0;
      q_q   <= 1'b0;
      cnt_q <= '0;
    end else begin
      s1_q  <= s1_d;
      s2_q  <= s2_d;
      q_q   <= q_d;
      cnt_q <= cnt_d;
    end
  end

  assign q = q_q;

endmodule

// File: rtl/sw_input_mmio.sv
// Memory-mapped switch responder: debounced state, sticky W1C edge flags, IRQ mask.
module sw_input_mmio
  import sw_input_pkg::*;
#(
  parameter int N         = 16,
  parameter int DB_CYCLES = 1000000
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic [N-1:0] sw_raw,
  input  logic         sel,
  input  logic         we,
  input  logic [3:0]   addr,
  input  logic [31:0]  wdata,
  output logic [31:0]  rdata,
  output logic         irq
);

  logic [N-1:0] db_state, db_rise, db_fall;
  logic [N-1:0] rise_q, rise_d;
  logic [N-1:0] fall_q, fall_d;
  logic [N-1:0] irq_en_q, irq_en_d;
  logic         wr;

  for (genvar i = 0; i < N; i++) begin : g_db
    sw_debounce_bit #(.DB_CYCLES(DB_CYCLES)) u_db (
      .clk  (clk),
      .rstn (rstn),
      .raw  (sw_raw[i]),
      .q    (db_state[i]),
      .rise (db_rise[i]),
      .fall (db_fall[i])
    );
  end

  assign wr = sel & we;

  // A new edge on the same cycle as a clear keeps the flag set
  always_comb begin
    rise_d   = (rise_q & ~((wr && addr[3:2] == SWIN_RISE) ? wdata[N-1:0] : '0)) | db_rise;
    fall_d   = (fall_q & ~((wr && addr[3:2] == SWIN_FALL) ? wdata[N-1:0] : '0)) | db_fall;
    irq_en_d = (wr && addr[3:2] == SWIN_IRQEN) ? wdata[N-1:0] : irq_en_q;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rise_q   <= '0;
      fall_q   <= '0;
      irq_en_q <= '0;
    end else begin
      rise_q   <= rise_d;
      fall_q   <= fall_d;
      irq_en_q <= irq_en_d;
    end
  end

  always_comb begin
    rdata = '0;
    if (sel) begin
      case (addr[3:2])
        SWIN_DATA:  rdata[N-1:0] = db_state;
        SWIN_RISE:  rdata[N-1:0] = rise_q;
        SWIN_FALL:  rdata[N-1:0] = fall_q;
        default:    rdata[N-1:0] = irq_en_q;
      endcase
    end
  end

  assign irq = |(rise_q & irq_en_q);

  logic unused_addr_lsb;
  assign unused_addr_lsb = ^addr[1:0];

  if (N < 32) begin : g_unused_wdata
    logic unused_wdata_hi;
    assign unused_wdata_hi = ^wdata[31:N];
  end

endmodule

// File: tb/tb_sw_input_mmio.sv
// Directed bench for sw_input_mmio with N=16, DB_CYCLES=4 and a queue scoreboard.
module tb_sw_input_mmio;

  localparam int N  = 16;
  localparam int DB = 4;

  logic          clk = 1'b0;
  logic          rstn;
  logic [N-1:0]  sw_raw;
  logic          sel;
  logic          we;
  logic [3:0]    addr;
  logic [31:0]   wdata;
  logic [31:0]   rdata;
  logic          irq;

  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] sb_q[$];
  string       tag_q[$];

  sw_input_mmio #(.N(N), .DB_CYCLES(DB)) dut (
    .clk    (clk),
    .rstn   (rstn),
    .sw_raw (sw_raw),
    .sel    (sel),
    .we     (we),
    .addr   (addr),
    .wdata  (wdata),
    .rdata  (rdata),
    .irq    (irq)
  );

  always #10 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic expect_val(input string tag, input logic [31:0] e);
    sb_q.push_back(e);
    tag_q.push_back(tag);
  endtask

  task automatic compare(input logic [31:0] obs);
    logic [31:0] e;
    string t;
    e = sb_q.pop_front();
    t = tag_q.pop_front();
    n_cmp++;
    assert (obs === e) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", t, obs, e);
    end
  endtask

  task automatic rd(input string tag, input logic [3:0] a, input logic [31:0] e);
    expect_val(tag, e);
    sel  = 1'b1;
    we   = 1'b0;
    addr = a;
    #1;
    compare(rdata);
    sel  = 1'b0;
  endtask

  task automatic chk_irq(input string tag, input logic e);
    expect_val(tag, {31'd0, e});
    #1;
    compare({31'd0, irq});
  endtask

  task automatic wr(input logic [3:0] a, input logic [31:0] d);
    sel   = 1'b1;
    we    = 1'b1;
    addr  = a;
    wdata = d;
    @(negedge clk);
    sel   = 1'b0;
    we    = 1'b0;
    wdata = '0;
  endtask

  initial begin
    rstn   = 1'b0;
    sw_raw = '0;
    sel    = 1'b0;
    we     = 1'b0;
    addr   = '0;
    wdata  = '0;
    tick(3);
    rstn = 1'b1;

    rd("rst_data", 4'h0, 32'h0);
    rd("rst_rise", 4'h4, 32'h0);
    rd("rst_fall", 4'h8, 32'h0);
    rd("rst_irqen", 4'hC, 32'h0);
    chk_irq("rst_irq", 1'b0);

    // Clean rise on bit 3: accepted on the sixth edge after the change
    sw_raw[3] = 1'b1;
    tick(DB + 1);
    rd("rise3_early_data", 4'h0, 32'h0);
    rd("rise3_early_flag", 4'h4, 32'h0);
    tick(1);
    rd("rise3_data", 4'h0, 32'h0008);
    rd("rise3_flag", 4'h4, 32'h0008);

    // Bounce on bit 5 never stays stable long enough
    for (int i = 0; i < 20; i++) begin
      sw_raw[5] = ~sw_raw[5];
      tick(2);
      rd("bounce_data", 4'h0, 32'h0008);
      rd("bounce_rise", 4'h4, 32'h0008);
    end
    rd("bounce_fall", 4'h8, 32'h0);
    sw_raw[5] = 1'b1;
    tick(DB + 1);
    rd("bounce_hold_early", 4'h4, 32'h0008);
    tick(1);
    rd("bounce_hold_rise", 4'h4, 32'h0028);
    rd("bounce_hold_data", 4'h0, 32'h0028);

    // Store and load to RISE in the same cycle sees the pre-write value
    sel = 1'b1; we = 1'b1; addr = 4'h4; wdata = 32'h0020;
    expect_val("w1c_same_cycle", 32'h0028);
    #1;
    compare(rdata);
    @(negedge clk);
    sel = 1'b0; we = 1'b0; wdata = '0;
    rd("w1c_bit5", 4'h4, 32'h0008);

    wr(4'h0, 32'hFFFF);
    rd("data_ro", 4'h0, 32'h0028);

    sw_raw[0] = 1'b1;
    tick(DB + 2);
    rd("rise_0009", 4'h4, 32'h0009);
    wr(4'h4, 32'h0001);
    rd("w1c_bit0", 4'h4, 32'h0008);

    sw_raw[0] = 1'b0;
    tick(DB + 2);
    rd("fall0", 4'h8, 32'h0001);
    rd("fall0_data", 4'h0, 32'h0028);

    // Clear lands on the same edge as a new rise: set wins
    sw_raw[0] = 1'b1;
    tick(DB + 1);
    wr(4'h4, 32'h0001);
    rd("set_wins", 4'h4, 32'h0009);
    wr(4'h8, 32'hFFFF);
    rd("fall_clr", 4'h8, 32'h0);

    wr(4'hC, 32'h0100);
    rd("irqen", 4'hC, 32'h0100);
    chk_irq("irq_masked", 1'b0);

    sel = 1'b0; we = 1'b1; addr = 4'hC; wdata = 32'hFFFF;
    expect_val("nosel_rdata", 32'h0);
    #1;
    compare(rdata);
    @(negedge clk);
    we = 1'b0; wdata = '0;
    rd("nosel_irqen", 4'hC, 32'h0100);

    sw_raw[8] = 1'b1;
    tick(DB + 1);
    chk_irq("irq8_early", 1'b0);
    tick(1);
    chk_irq("irq8", 1'b1);
    rd("irq8_rise", 4'h4, 32'h0109);
    wr(4'h4, 32'h0100);
    chk_irq("irq8_clr", 1'b0);
    rd("irq8_clr_rise", 4'h4, 32'h0009);

    sw_raw[2] = 1'b1;
    tick(DB + 2);
    rd("rise2", 4'h4, 32'h000D);
    chk_irq("irq_bit2", 1'b0);

    sw_raw[7] = 1'b1;
    tick(DB + 2);
    rd("bit7_hi", 4'h0, 32'h01AD);
    rd("bit7_rise", 4'h4, 32'h008D);
    sw_raw[7] = 1'b0;
    tick(DB + 2);
    rd("bit7_fall", 4'h8, 32'h0080);
    rd("bit7_lo", 4'h0, 32'h012D);

    sw_raw = '0;
    tick(DB + 2);
    rd("all_lo_data", 4'h0, 32'h0);
    rd("all_lo_fall", 4'h8, 32'h01AD);

    // Reset mid-count on bit 10
    sw_raw[10] = 1'b1;
    tick(DB);
    rstn = 1'b0;
    sw_raw[10] = 1'b0;
    tick(1);
    rstn = 1'b1;
    rd("rst2_data", 4'h0, 32'h0);
    rd("rst2_rise", 4'h4, 32'h0);
    rd("rst2_fall", 4'h8, 32'h0);
    rd("rst2_irqen", 4'hC, 32'h0);
    chk_irq("rst2_irq", 1'b0);
    tick(2 * DB);
    rd("abort_rise", 4'h4, 32'h0);
    rd("abort_data", 4'h0, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/sw_input_mmio.md
# sw_input_mmio

Memory-mapped switch-input responder for the single-cycle CPU's data bus. It synchronises and debounces the 16 board switches and exposes four registers at a decoded base address:
- debounced switch state;
- sticky rising-edge flags;
- sticky falling-edge flags;
- interrupt-enable mask.

Programs can then poll, or take an interrupt on, switch changes instead of the top level wiring `sw_i` directly into display and control logic. It sits beside the data memory; the CPU selects between the two read paths by address decode.

## Interface
Parameters:
- `N`, 16, number of switch inputs (1..32).
- `DB_CYCLES`, 1000000, consecutive stable cycles required to accept a new level (≥2).

Ports:
- `clk`  in  1  clock.
- `rstn`  in  1  reset, asynchronous, active-low.
- `sw_raw`  in  N  asynchronous switch pins.
- `sel`  in  1  chip select from the CPU address decode.
- `we`  in  1  store strobe; takes effect on the `clk` rising edge when `sel=1`.
- `addr`  in  4  byte offset; only `[3:2]` are decoded, `[1:0]` are ignored.
- `wdata`  in  32  store data.
- `rdata`  out  32  load data; combinational.
- `irq`  out  1  level interrupt: `|(RISE & IRQ_EN)`.

## Operation
- **Register map** (word offset via `addr[3:2]`):
  - 0 `DATA`: read-only, debounced state. Writes are ignored.
  - 1 `RISE`: sticky rising-edge flags, write-1-to-clear.
  - 2 `FALL`: sticky falling-edge flags, write-1-to-clear.
  - 3 `IRQ_EN`: read/write mask. Stores `wdata[N-1:0]`.
- **Read data:** `rdata` bits above `N-1` read 0. `rdata` = 0 when `sel=0`.
- **Per-bit pipeline:**
  - Two-flop synchroniser `s1 → s2`.
  - Counter `cnt` of width `$clog2(DB_CYCLES)`.
  - Stable bit `q`.
- **Debounce rule** (applied every edge):
  - If `s2==q`: `cnt<=0`.
  - Else if `cnt==DB_CYCLES-1`: `q<=s2`, `cnt<=0`, pulse `rise` if `s2=1`, else pulse `fall`.
  - Else: `cnt<=cnt+1`.
- **Any glitch resets the count:** a return of `s2` to `q` before the count completes forces `cnt<=0`.
- **Flag update:** `RISE[i] <= (RISE[i] & ~clr[i]) | rise[i]`, where `clr = wdata` when writing offset 1. `FALL` uses the same rule with offset 2. Set wins over a simultaneous clear.
- **Reset values:** `s1`, `s2`, `q`, `cnt`, `RISE`, `FALL`, `IRQ_EN` = 0, so `rdata`=0 and `irq`=0.
- **Switches already on at reset** produce a `RISE` flag once debounced. This is intentional; software clears it at boot.
- **Reset mid-count** discards any partial count. No flag is produced for that count.

## Timing
- Raw change first sampled at edge k:
  - `s2` updates at edge k+1.
  - `q` and the edge flag update at edge k+1+`DB_CYCLES`.
  - `irq` follows combinationally in the same cycle.
- **Register writes:** visible on `rdata` the cycle after the write edge.
- **W1C:** takes effect at the write edge. A store and a load to the same offset in one cycle returns the pre-write value.
- **`irq`:**
  - Deasserts the cycle after the last enabled `RISE` bit is cleared, unless a new rise arrives on that same edge.
  - Also deasserts the cycle after `IRQ_EN` is written to 0.
- **No wait states:** zero-latency read, single-edge write. No stall handshake is needed by the single-cycle core.

## Structure
- **Shared package `sw_input_pkg`:**
  - offsets `SWIN_DATA=2'd0`, `SWIN_RISE=2'd1`, `SWIN_FALL=2'd2`, `SWIN_IRQEN=2'd3`;
  - `SWIN_BASE` for the top-level address decode.
- **Sub-module `sw_debounce_bit`:**
  - Ports: `clk`, `rstn`, `raw`, `q`, `rise`, `fall`; parameter `DB_CYCLES`.
  - Holds the synchroniser, counter and stable bit.
  - Instantiated N times via generate.
- **Top `sw_input_mmio`:** flag registers, mask register, read mux and `irq`.

## Test plan
All scenarios use N=16, DB_CYCLES=4.
- **Clean rise:** `sw_raw[3]` 0→1 before edge 10 → `DATA`=`0x0008` and `RISE`=`0x0008` first readable after edge 15. Before edge 15, `DATA`=0.
- **Bounce rejection:** `sw_raw[5]` toggled every 2 cycles for 40 cycles, then held 1 →
  - `DATA[5]`=0 and no flags throughout the toggling;
  - a single `RISE[5]` set 5 edges after the final change is sampled.
- **W1C and precedence:**
  - With `RISE`=`0x0009`, write `0x0001` to offset 4 → `RISE`=`0x0008`.
  - Repeat the write on the same edge as a new rise on bit 0 → `RISE`=`0x0009`.
- **Interrupt:** `IRQ_EN`=`0x0100`, raise bit 8 → `irq`=1 with `RISE[8]`. Write `0x0100` to offset 4 → `irq`=0 the next cycle. A rise on bit 2 leaves `irq`=0.
- **Fall and reset:**
  - Bit 7 1→0 → `FALL`=`0x0080`, `DATA[7]`=0.
  - Assert `rstn` low for 1 cycle mid-count on another bit → all registers 0, `rdata`=0, `irq`=0; no flag from the aborted count.
- **Select gating:** `sel`=0 with `we`=1, `addr`=`0xC`, `wdata`=`0xFFFF` → `IRQ_EN` unchanged and `rdata`=0.
